// File: rtl/blockmem_clr_if.sv
// Access port of the clearable block memory: handshake, read and write buses.
// The master drives requests; the slave returns ready, read data and read-valid.
interface blockmem_clr_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
);
    logic                  init;
    logic                  ready;
    logic                  rd;
    logic [ADDR_WIDTH-1:0] read_addr;
    logic [DATA_WIDTH-1:0] read_data;
    logic                  read_valid;
    logic                  wr;
    logic [ADDR_WIDTH-1:0] write_addr;
    logic [DATA_WIDTH-1:0] write_data;

    modport master (
        output init, rd, read_addr, wr, write_addr, write_data,
        input  ready, read_data, read_valid
    );

    modport slave (
        input  init, rd, read_addr, wr, write_addr, write_data,
        output ready, read_data, read_valid
    );
endinterface

// File: rtl/blockmem_clr.sv
// Block memory with write-first bypass and a clear sweep after reset or init; read latency 1 cycle.
// No backpressure: accesses are only honoured while ready is high, and are silently dropped otherwise.
module blockmem_clr #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic          clk,
    input  logic          reset,
    blockmem_clr_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {CTRL_CLEAR, CTRL_IDLE} ctrl_t;

    ctrl_t                 ctrl_q, ctrl_d;
    logic [ADDR_WIDTH-1:0] clear_addr_q, clear_addr_d;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  rd_acc;
    logic [DATA_WIDTH-1:0] read_data_q;
    logic                  read_valid_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q       <= CTRL_CLEAR;
            clear_addr_q <= '0;
        end else begin
            ctrl_q       <= ctrl_d;
            clear_addr_q <= clear_addr_d;
        end
    end

    // Single write port shared by the sweep and the access port; init wins over both.
    always_comb begin
        ctrl_d       = ctrl_q;
        clear_addr_d = clear_addr_q;
        mem_we       = 1'b0;
        mem_waddr    = clear_addr_q;
        mem_wdata    = CLEAR_VALUE;
        rd_acc       = 1'b0;
        case (ctrl_q)
            CTRL_CLEAR: begin
                if (bus.init) begin
                    clear_addr_d = '0;
                end else begin
                    mem_we       = 1'b1;
                    clear_addr_d = clear_addr_q + ADDR_WIDTH'(1);
                    if (&clear_addr_q) begin
                        ctrl_d = CTRL_IDLE;
                    end
                end
            end
            CTRL_IDLE: begin
                if (bus.init) begin
                    ctrl_d       = CTRL_CLEAR;
                    clear_addr_d = '0;
                end else begin
                    mem_we    = bus.wr;
                    mem_waddr = bus.write_addr;
                    mem_wdata = bus.write_data;
                    rd_acc    = bus.rd;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Same-address read and write in one cycle returns the new data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            read_data_q  <= '0;
            read_valid_q <= 1'b0;
        end else begin
            read_valid_q <= rd_acc;
            if (rd_acc) begin
                read_data_q <= (bus.wr && (bus.write_addr == bus.read_addr))
                             ? bus.write_data : mem[bus.read_addr];
            end
        end
    end

    assign bus.ready      = (ctrl_q == CTRL_IDLE);
    assign bus.read_data  = read_data_q;
    assign bus.read_valid = read_valid_q;
endmodule

// File: tb/tb_blockmem_clr.sv
// Directed bench for blockmem_clr with CLEAR_VALUE = 0x5A5A5A5A and default geometry.
module tb_blockmem_clr;
    localparam logic [31:0] CV = 32'h5A5A_5A5A;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   nvec = 0;
    int   errs = 0;

    always #5 clk = ~clk;

    blockmem_clr_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) bus ();

    blockmem_clr #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (8),
        .CLEAR_VALUE(CV)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input string tag, input int exp_n);
        int n;
        n = 0;
        while (bus.ready !== 1'b1 && n < 1000) begin
            tick();
            n++;
        end
        chk(tag, 32'(n), 32'(exp_n));
    endtask

    task automatic wr_word(input logic [7:0] a, input logic [31:0] d);
        bus.wr         = 1'b1;
        bus.write_addr = a;
        bus.write_data = d;
        tick();
        bus.wr = 1'b0;
    endtask

    task automatic read_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
        bus.rd        = 1'b1;
        bus.read_addr = a;
        tick();
        bus.rd = 1'b0;
        chk({tag, "_valid"}, 32'(bus.read_valid), 32'd1);
        chk({tag, "_data"}, bus.read_data, exp);
        tick();
        chk({tag, "_valid_drop"}, 32'(bus.read_valid), 32'd0);
    endtask

    initial begin
        bus.init       = 1'b0;
        bus.rd         = 1'b0;
        bus.read_addr  = '0;
        bus.wr         = 1'b0;
        bus.write_addr = '0;
        bus.write_data = '0;

        // reset state and power-up sweep
        repeat (3) tick();
        chk("rst_ready", 32'(bus.ready), 32'd0);
        chk("rst_valid", 32'(bus.read_valid), 32'd0);
        chk("rst_data", bus.read_data, 32'd0);
        reset = 1'b0;
        wait_ready("sweep_edges", 256);
        read_chk("clr0", 8'd0, CV);
        read_chk("clr17", 8'd17, CV);
        read_chk("clr255", 8'd255, CV);

        // write then back-to-back reads
        wr_word(8'h10, 32'hDEAD_BEEF);
        wr_word(8'hFF, 32'h0123_4567);
        bus.rd = 1'b1; bus.read_addr = 8'h10;
        tick();
        chk("b2b0_valid", 32'(bus.read_valid), 32'd1);
        chk("b2b0_data", bus.read_data, 32'hDEAD_BEEF);
        bus.read_addr = 8'hFF;
        tick();
        bus.rd = 1'b0;
        chk("b2b1_valid", 32'(bus.read_valid), 32'd1);
        chk("b2b1_data", bus.read_data, 32'h0123_4567);
        tick();
        chk("b2b_valid_drop", 32'(bus.read_valid), 32'd0);

        // write-first collision, then independent read/write on different addresses
        wr_word(8'h20, 32'h1111_1111);
        bus.wr = 1'b1; bus.write_addr = 8'h20; bus.write_data = 32'h2222_2222;
        bus.rd = 1'b1; bus.read_addr = 8'h20;
        tick();
        chk("coll_data", bus.read_data, 32'h2222_2222);
        chk("coll_valid", 32'(bus.read_valid), 32'd1);
        bus.write_addr = 8'h21; bus.write_data = 32'h3333_3333;
        tick();
        bus.wr = 1'b0; bus.rd = 1'b0;
        chk("split_data", bus.read_data, 32'h2222_2222);
        read_chk("coll_later", 8'h20, 32'h2222_2222);
        read_chk("split_wr", 8'h21, 32'h3333_3333);

        // init drops same-cycle accesses and clears everything
        for (int i = 0; i < 4; i++) wr_word(8'(i), 32'h1000_0000 + 32'(i));
        bus.init = 1'b1;
        bus.wr = 1'b1; bus.write_addr = 8'h04; bus.write_data = 32'hCAFE_F00D;
        bus.rd = 1'b1; bus.read_addr = 8'h00;
        tick();
        bus.init = 1'b0; bus.wr = 1'b0; bus.rd = 1'b0;
        chk("init_ready", 32'(bus.ready), 32'd0);
        chk("init_valid", 32'(bus.read_valid), 32'd0);
        chk("init_data_hold", bus.read_data, 32'h3333_3333);
        wait_ready("init_edges", 256);
        for (int i = 0; i < 5; i++) read_chk($sformatf("init_clr%0d", i), 8'(i), CV);

        // accesses during a sweep are ignored
        bus.init = 1'b1;
        tick();
        bus.init = 1'b0;
        repeat (100) tick();
        bus.wr = 1'b1; bus.write_addr = 8'h30; bus.write_data = 32'hAAAA_AAAA;
        bus.rd = 1'b1; bus.read_addr = 8'h30;
        tick();
        bus.wr = 1'b0; bus.rd = 1'b0;
        chk("busy_valid", 32'(bus.read_valid), 32'd0);
        chk("busy_data_hold", bus.read_data, CV);
        wait_ready("busy_edges", 155);
        read_chk("busy_wr_dropped", 8'h30, CV);

        // init restart mid-sweep at address 100
        bus.init = 1'b1;
        tick();
        bus.init = 1'b0;
        repeat (100) tick();
        bus.init = 1'b1;
        tick();
        bus.init = 1'b0;
        wait_ready("restart_edges", 256);

        // asynchronous reset mid-sweep at address 50
        bus.init = 1'b1;
        tick();
        bus.init = 1'b0;
        repeat (50) tick();
        #2 reset = 1'b1;
        #1;
        chk("arst_sweep_ready", 32'(bus.ready), 32'd0);
        chk("arst_sweep_data", bus.read_data, 32'd0);
        tick();
        #2 reset = 1'b0;
        wait_ready("arst_sweep_edges", 256);

        // asynchronous reset while read_valid is high
        bus.rd = 1'b1; bus.read_addr = 8'h00;
        tick();
        chk("arst_acc_pre_valid", 32'(bus.read_valid), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("arst_acc_valid", 32'(bus.read_valid), 32'd0);
        chk("arst_acc_data", bus.read_data, 32'd0);
        chk("arst_acc_ready", 32'(bus.ready), 32'd0);
        bus.rd = 1'b0;
        tick();
        #2 reset = 1'b0;
        wait_ready("arst_acc_edges", 256);
        read_chk("final", 8'h00, CV);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
        $finish;
    end
endmodule
